// File: rtl/sp_ram_bist.sv
// March-style BIST for a single-port RAM: write a seeded pattern, read it back,
// then repeat with the inverted seed. Errors are counted and the first failure is logged.

module sp_ram_bist_lane_cmp #(
    parameter int VEC_W = 8
) (
    input  logic [VEC_W-1:0] rd,
    input  logic [VEC_W-1:0] exp,
    output logic             miss
);
    assign miss = (rd != exp);
endmodule

module sp_ram_bist #(
    parameter int RAM_SIZE   = 32768,
    parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rstn_i,
    input  logic                    start_i,
    input  logic [DATA_WIDTH-1:0]   pattern_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    pass_o,
    output logic [15:0]             err_cnt_o,
    output logic [ADDR_WIDTH-1:0]   fail_addr_o,
    output logic [DATA_WIDTH-1:0]   fail_data_o,
    output logic                    ram_en_o,
    output logic                    ram_we_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);
    localparam int N         = RAM_SIZE / 4;
    localparam int IW        = ADDR_WIDTH - 2;
    localparam int VEC_W     = 8;
    localparam int NUM_LANES = DATA_WIDTH / VEC_W;
    localparam int STAGES    = 1;

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    typedef struct packed {
        logic                  en;
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [NUM_LANES-1:0]  be;
    } ram_req_t;

    state_t                state, state_nxt;
    logic [IW-1:0]         idx, idx_nxt;
    logic                  pass, pass_nxt;
    logic [DATA_WIDTH-1:0] pat;
    ram_req_t              req;
    logic                  start_acc;
    logic                  last;
    logic [DATA_WIDTH-1:0] exp_cur, exp_q;
    logic [ADDR_WIDTH-1:0] addr_cur, addr_q;
    logic [STAGES:0]       vld_pipe;
    logic [NUM_LANES-1:0]  lane_miss;
    logic                  mismatch;
    logic                  first_seen;
    logic [15:0]           err_cnt;
    logic [ADDR_WIDTH-1:0] fail_addr;
    logic [DATA_WIDTH-1:0] fail_data;

    assign start_acc = ((state == IDLE) || (state == DONE)) && start_i;
    assign last      = (idx == IW'(N - 1));
    assign exp_cur   = (pass ? ~pat : pat) ^ DATA_WIDTH'(idx);
    assign addr_cur  = {idx, 2'b00};

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= IDLE;
            idx   <= '0;
            pass  <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            pass  <= pass_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        pass_nxt  = pass;
        req       = '0;
        case (state)
            IDLE, DONE: begin
                if (start_acc) begin
                    state_nxt = WRITE;
                    idx_nxt   = '0;
                    pass_nxt  = 1'b0;
                end
            end
            WRITE: begin
                req.en    = 1'b1;
                req.we    = 1'b1;
                req.addr  = addr_cur;
                req.wdata = exp_cur;
                req.be    = '1;
                if (last) begin
                    state_nxt = READ;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + IW'(1);
                end
            end
            READ: begin
                req.en   = 1'b1;
                req.addr = addr_cur;
                if (last) begin
                    state_nxt = DRAIN;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + IW'(1);
                end
            end
            DRAIN: begin
                idx_nxt = '0;
                if (pass) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = WRITE;
                    pass_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read data returns one cycle after the request, so the expected word and
    // its address travel alongside a valid bit to line up with ram_rdata_i.
    assign vld_pipe[0] = (state == READ);

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            vld_pipe[STAGES:1] <= '0;
            exp_q              <= '0;
            addr_q             <= '0;
        end else begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            if (vld_pipe[0]) begin
                exp_q  <= exp_cur;
                addr_q <= addr_cur;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            pat <= '0;
        end else if (start_acc) begin
            pat <= pattern_i;
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        sp_ram_bist_lane_cmp #(.VEC_W(VEC_W)) u_cmp (
            .rd   (ram_rdata_i[l*VEC_W +: VEC_W]),
            .exp  (exp_q[l*VEC_W +: VEC_W]),
            .miss (lane_miss[l])
        );
    end

    assign mismatch = vld_pipe[STAGES] && (|lane_miss);

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            err_cnt    <= '0;
            first_seen <= 1'b0;
            fail_addr  <= '0;
            fail_data  <= '0;
        end else if (start_acc) begin
            err_cnt    <= '0;
            first_seen <= 1'b0;
            fail_addr  <= '0;
            fail_data  <= '0;
        end else if (mismatch) begin
            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            if (!first_seen) begin
                first_seen <= 1'b1;
                fail_addr  <= addr_q;
                fail_data  <= ram_rdata_i;
            end
        end
    end

    assign busy_o      = (state == WRITE) || (state == READ) || (state == DRAIN);
    assign done_o      = (state == DONE);
    assign pass_o      = done_o && (err_cnt == 16'd0);
    assign err_cnt_o   = err_cnt;
    assign fail_addr_o = fail_addr;
    assign fail_data_o = fail_data;
    assign ram_en_o    = req.en;
    assign ram_we_o    = req.we;
    assign ram_addr_o  = req.addr;
    assign ram_wdata_o = req.wdata;
    assign ram_be_o    = req.be;

endmodule

// File: tb/tb_sp_ram_bist.sv
// Randomized bench for sp_ram_bist: a faulty-RAM model plus a cycle-level timeline
// model derived from the test algorithm, checked on every falling edge.

module tb_sp_ram_bist;
    localparam int N    = 16;
    localparam int BUSY = 2 * (2 * N + 1);

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] pattern = '0;
    logic        busy, done, pass;
    logic [15:0] err_cnt;
    logic [5:0]  fail_addr;
    logic [31:0] fail_data;
    logic        ram_en, ram_we;
    logic [5:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_be;
    logic [31:0] ram_rdata = '0;

    int tests = 0;
    int fails = 0;

    sp_ram_bist #(.RAM_SIZE(64), .ADDR_WIDTH(6), .DATA_WIDTH(32)) dut (
        .clk(clk), .rstn_i(rstn), .start_i(start), .pattern_i(pattern),
        .busy_o(busy), .done_o(done), .pass_o(pass), .err_cnt_o(err_cnt),
        .fail_addr_o(fail_addr), .fail_data_o(fail_data),
        .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
        .ram_wdata_o(ram_wdata), .ram_be_o(ram_be), .ram_rdata_i(ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM fault description: affected words return (data & and_m) | or_m
    logic        fault_all = 1'b0;
    int          fault_word = -1;
    logic [31:0] and_m = '1;
    logic [31:0] or_m = '0;
    logic [31:0] mem [16];

    function automatic logic [31:0] apply_fault(input logic [31:0] d, input int w);
        if (fault_all || w == fault_word) return (d & and_m) | or_m;
        return d;
    endfunction

    always @(posedge clk) begin
        if (ram_en && ram_we) mem[ram_addr[5:2]] <= ram_wdata;
        if (ram_en && !ram_we) ram_rdata <= apply_fault(mem[ram_addr[5:2]], int'(ram_addr[5:2]));
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: k counts cycles since the start was accepted
    bit          m_busy = 0, m_done = 0;
    int          k = 0;
    logic [31:0] m_pat = '0;
    int          m_err = 0;
    logic [5:0]  m_faddr = '0;
    logic [31:0] m_fdata = '0;

    function automatic logic [31:0] exp_word(input int i, input int p);
        return (p != 0 ? ~m_pat : m_pat) ^ 32'(i);
    endfunction

    task automatic predict();
        logic [31:0] e, g;
        bit first = 0;
        m_err = 0; m_faddr = '0; m_fdata = '0;
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < N; i++) begin
                e = exp_word(i, p);
                g = apply_fault(e, i);
                if (g != e) begin
                    m_err++;
                    if (!first) begin
                        first = 1; m_faddr = 6'(i * 4); m_fdata = g;
                    end
                end
            end
    endtask

    initial forever begin
        @(posedge clk or negedge rstn);
        if (!rstn) begin
            m_busy = 0; m_done = 0; k = 0; m_err = 0; m_faddr = '0; m_fdata = '0;
        end else if (!m_busy && start) begin
            m_busy = 1; m_done = 0; k = 0; m_pat = pattern;
            predict();
        end else if (m_busy) begin
            k++;
            if (k == BUSY) begin m_busy = 0; m_done = 1; end
        end
    end

    int busy_run = 0;
    int busy_len = 0;

    initial begin
        int p, j;
        logic        e_en, e_we;
        logic [5:0]  e_addr;
        logic [31:0] e_wd;
        logic [3:0]  e_be;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                check("reset_outputs", {busy, done, pass, ram_en, ram_we, ram_addr, ram_wdata, ram_be},
                      '0);
                check("reset_results", {err_cnt, fail_addr, fail_data}, '0);
            end else begin
                e_en = 0; e_we = 0; e_addr = '0; e_wd = '0; e_be = '0;
                if (m_busy) begin
                    p = k / (2 * N + 1);
                    j = k % (2 * N + 1);
                    if (j < N) begin
                        e_en = 1; e_we = 1; e_addr = 6'(j * 4); e_wd = exp_word(j, p); e_be = 4'hF;
                    end else if (j < 2 * N) begin
                        e_en = 1; e_addr = 6'((j - N) * 4);
                    end
                end
                check("busy", busy, m_busy);
                check("done", done, m_done);
                check("ram_req", {ram_en, ram_we, ram_addr, ram_wdata, ram_be},
                      {e_en, e_we, e_addr, e_wd, e_be});
                if (m_done) begin
                    check("err_cnt", err_cnt, m_err);
                    check("fail_addr", fail_addr, m_faddr);
                    check("fail_data", fail_data, m_fdata);
                    check("pass", pass, m_err == 0);
                end else begin
                    check("pass_low", pass, 0);
                    if (!m_busy || k == 0)
                        check("results_clear", {err_cnt, fail_addr, fail_data}, '0);
                end
            end
            if (busy) busy_run++;
            else if (busy_run > 0) begin busy_len = busy_run; busy_run = 0; end
        end
    end

    task automatic wait_done();
        for (int c = 0; c < 300 && !done; c++) @(negedge clk);
        check("done_timeout", done, 1);
        #1;
    endtask

    task automatic run_test(input logic [31:0] pat);
        pattern = pat;
        start = 1;
        @(negedge clk);
        start = 0;
        check("first_write", {ram_en, ram_we, ram_addr, ram_wdata}, {1'b1, 1'b1, 6'd0, pat});
        wait_done();
        check("busy_len", busy_len, BUSY);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rstn = 1;
        repeat (4) @(negedge clk);

        // clean RAM
        run_test(32'hA5A5A5A5);
        check("t1_err", err_cnt, 0);
        check("t1_pass", pass, 1);
        check("t1_busy66", busy_len, 66);

        // bit 3 stuck-at-1 at word 5
        fault_word = 5; and_m = '1; or_m = 32'h8;
        run_test(32'hA5A5A5A5);
        check("t2_err", err_cnt, 1);
        check("t2_addr", fail_addr, 6'h14);
        check("t2_data", fail_data, 32'hA5A5A5A8);
        check("t2_pass", pass, 0);

        // reset during pass-0 READ
        fault_word = -1; or_m = '0;
        pattern = 32'hA5A5A5A5;
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (20) @(negedge clk);
        check("t3_in_read", {ram_en, ram_we, ram_addr}, {1'b1, 1'b0, 6'h10});
        #3 rstn = 0;
        #1 check("t3_async_zero", {busy, done, pass, ram_en, ram_we, ram_addr, ram_wdata, ram_be, err_cnt},
                 '0);
        repeat (2) @(negedge clk);
        #3 rstn = 1;
        @(negedge clk);
        run_test(32'hA5A5A5A5);
        check("t3_pass", pass, 1);

        // start held high: ignored while busy, re-accepted in DONE
        fault_word = 5; or_m = 32'h8;
        pattern = 32'hA5A5A5A5;
        start = 1;
        @(negedge clk);
        wait_done();
        check("t4_err", err_cnt, 1);
        check("t4_busy66", busy_len, 66);
        @(negedge clk);
        check("t4_restart", {busy, done, err_cnt}, {1'b1, 1'b0, 16'd0});
        start = 0;
        wait_done();
        check("t4_err2", err_cnt, 1);

        // RAM returns zeros everywhere
        fault_word = -1; fault_all = 1; and_m = '0; or_m = '0;
        run_test(32'hA5A5A5A5);
        check("t5_err", err_cnt, 32);
        check("t5_addr", fail_addr, 0);
        check("t5_pass", pass, 0);
        fault_all = 0; and_m = '1;

        // random patterns and single stuck bits
        for (int r = 0; r < 4; r++) begin
            int b;
            fault_word = int'($urandom_range(0, 15));
            b = int'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) begin and_m = '1; or_m = 32'h1 << b; end
            else begin and_m = ~(32'h1 << b); or_m = '0; end
            run_test($urandom);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sp_ram_bist.md
SP_RAM_BIST -- requirements
Module: sp_ram_bist

Interface
REQ-001 SHALL have parameter RAM_SIZE, default 32768, memory size in bytes; must be a power of two and at least 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default $clog2(RAM_SIZE), byte-address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 rstn_i  input  1  reset, asynchronous and active-low.
REQ-006 start_i  input  1  level-sampled request to begin a test.
REQ-007 pattern_i  input  DATA_WIDTH  seed pattern, captured when start is accepted.
REQ-008 busy_o  output  1  test in progress.
REQ-009 done_o  output  1  test finished; results are valid.
REQ-010 pass_o  output  1  high with done_o when err_cnt_o==0.
REQ-011 err_cnt_o  output  16  mismatch count, saturating.
REQ-012 fail_addr_o  output  ADDR_WIDTH  byte address of the first mismatch.
REQ-013 fail_data_o  output  DATA_WIDTH  read data of the first mismatch.
REQ-014 ram_en_o, ram_we_o  output  1 each  RAM request enable and write strobe.
REQ-015 ram_addr_o  output  ADDR_WIDTH  word-aligned byte address; bits [1:0] are always 0.
REQ-016 ram_wdata_o  output  DATA_WIDTH; ram_be_o  output  DATA_WIDTH/8  byte enables.
REQ-017 ram_rdata_i  input  DATA_WIDTH  RAM read data, valid exactly one cycle after a read request (ram_en_o=1, ram_we_o=0).

Function
REQ-018 Terms: N = RAM_SIZE/4 words; word index i = 0..N-1; ram_addr_o = {i, 2'b00}.
REQ-019 States SHALL be IDLE, WRITE, READ, DRAIN, DONE, plus a 1-bit pass counter p (0, then 1).
REQ-020 Expected data SHALL be E(i,p) = (p ? ~pattern : pattern) XOR zero-extended i.
REQ-021 IDLE or DONE with start_i=1 -> WRITE with i=0, p=0; SHALL capture pattern_i and clear err_cnt_o, the first-fail flag, fail_addr_o and fail_data_o; done_o drops.
REQ-022 start_i SHALL be ignored in WRITE, READ and DRAIN.
REQ-023 WRITE: one write per cycle; ram_en_o=1, ram_we_o=1, ram_be_o all ones, ram_wdata_o=E(i,p). At i=N-1 -> READ with i=0.
REQ-024 READ: one read per cycle; ram_en_o=1, ram_we_o=0. Expected value and address are registered for comparison in the following cycle. At i=N-1 -> DRAIN.
REQ-025 DRAIN: ram_en_o=0; compares the last read. If p=0 -> WRITE with p=1, i=0; else -> DONE.
REQ-026 Each compare cycle SHALL test ram_rdata_i against the registered expected value; every mismatch increments err_cnt_o, holding at 16'hFFFF.
REQ-027 On the first mismatch since start, fail_addr_o and fail_data_o SHALL capture the registered address and ram_rdata_i; later mismatches do not update them.
REQ-028 busy_o SHALL be 1 in WRITE, READ and DRAIN only; done_o SHALL be 1 in DONE only; pass_o = done_o AND (err_cnt_o==0).
REQ-029 Outside WRITE and READ: ram_en_o=0, ram_we_o=0, ram_be_o=0; ram_addr_o and ram_wdata_o=0.
REQ-030 Latency: first write is issued the cycle after start is accepted; busy duration is exactly 2*(2N+1) cycles; done_o is asserted on the next cycle.
REQ-031 A compare in a READ cycle and the state advance in the same cycle SHALL both take effect; no read is lost.

Reset
REQ-032 rstn_i low SHALL, asynchronously and at any time including mid-test, force IDLE, i=0, p=0, and drive all outputs to 0 (ram_en_o=0, ram_we_o=0).
REQ-033 After reset release, no RAM request SHALL be issued until start_i is accepted.

Verification
REQ-034 RAM_SIZE=64 (N=16) with an ideal 1-cycle RAM model, pattern 32'hA5A5A5A5, start pulse -> 16 writes of A5A5A5A5^i, 16 reads, then pass 1 with 5A5A5A5A^i; busy for 66 cycles, then done_o=1, pass_o=1, err_cnt_o=0.
REQ-035 Same setup, model bit 3 stuck-at-1 at word 5 -> err_cnt_o=1, fail_addr_o=0x14, fail_data_o=A5A5A5A5^5 with bit 3 set (pass 0 expected value bit 3 is 0).
REQ-036 Reset asserted during READ of pass 0 -> all outputs 0 in the same cycle; a new start afterwards completes with pass_o=1.
REQ-037 start_i held high throughout -> second start is ignored while busy; re-accepted in DONE, which clears err_cnt_o and restarts.
REQ-038 Model returns all zeros at every address -> err_cnt_o=32, fail_addr_o=0, pass_o=0.
